// File: rtl/reg_bus_cmd_decoder.sv
// Turns the UART receive byte stream into register-bus write transactions and buffer-request strobes.
// An inter-byte timeout drops a partial frame so framing resynchronises after line errors.
module reg_bus_cmd_decoder #(
    parameter int                       RX_DATA_WIDTH    = 8,
    parameter int                       REG_ADDR_WIDTH   = 8,
    parameter int                       REG_DATA_WIDTH   = 16,
    parameter logic [RX_DATA_WIDTH-1:0] OPCODE_REG_WRITE = 8'h01,
    parameter logic [RX_DATA_WIDTH-1:0] OPCODE_RQST_DATA = 8'h02,
    parameter int                       TIMEOUT_CYCLES   = 100000,
    parameter int                       TIMEOUT_WIDTH    = 17
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [RX_DATA_WIDTH-1:0]  rx_data,
    input  logic                      rx_rdy,
    output logic [REG_ADDR_WIDTH-1:0] register_addr,
    output logic [REG_DATA_WIDTH-1:0] register_data,
    output logic                      register_rdy,
    output logic                      rqst_data,
    output logic                      frame_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA_L, DATA_H} state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] TMO_MAX = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

    state_t                     state_q, state_d;
    logic [TIMEOUT_WIDTH-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic                       tmo_hit;

    logic [REG_ADDR_WIDTH-1:0]  shadow_addr_q, shadow_addr_d;
    logic [RX_DATA_WIDTH-1:0]   shadow_lo_q, shadow_lo_d;

    logic [REG_ADDR_WIDTH-1:0]  register_addr_q, register_addr_d;
    logic [REG_DATA_WIDTH-1:0]  register_data_q, register_data_d;
    logic                       register_rdy_q, register_rdy_d;
    logic                       rqst_data_q, rqst_data_d;
    logic                       frame_err_q, frame_err_d;

    // A byte arriving on the expiry cycle wins over the timeout.
    assign tmo_hit = (state_q != IDLE) && !rx_rdy && (tmo_cnt_q == TMO_MAX);

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (rx_rdy || state_q == IDLE) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TMO_MAX) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rx_rdy) begin
            case (state_q)
                IDLE:    state_d = (rx_data == OPCODE_REG_WRITE) ? ADDR : IDLE;
                ADDR:    state_d = DATA_L;
                DATA_L:  state_d = DATA_H;
                DATA_H:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end else if (tmo_hit) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        shadow_addr_d   = shadow_addr_q;
        shadow_lo_d     = shadow_lo_q;
        register_addr_d = register_addr_q;
        register_data_d = register_data_q;
        register_rdy_d  = 1'b0;
        rqst_data_d     = 1'b0;
        frame_err_d     = tmo_hit;
        if (rx_rdy) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == OPCODE_RQST_DATA) begin
                        rqst_data_d = 1'b1;
                    end else if (rx_data != OPCODE_REG_WRITE) begin
                        frame_err_d = 1'b1;
                    end
                end
                ADDR:   shadow_addr_d = REG_ADDR_WIDTH'(rx_data);
                DATA_L: shadow_lo_d   = rx_data;
                DATA_H: begin
                    register_addr_d = shadow_addr_q;
                    register_data_d = {rx_data, shadow_lo_q};
                    register_rdy_d  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Shadow bytes are always written before they are read, so they need no reset.
    always_ff @(posedge clk) begin
        shadow_addr_q <= shadow_addr_d;
        shadow_lo_q   <= shadow_lo_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            register_addr_q <= '0;
            register_data_q <= '0;
            register_rdy_q  <= 1'b0;
            rqst_data_q     <= 1'b0;
            frame_err_q     <= 1'b0;
        end else begin
            register_addr_q <= register_addr_d;
            register_data_q <= register_data_d;
            register_rdy_q  <= register_rdy_d;
            rqst_data_q     <= rqst_data_d;
            frame_err_q     <= frame_err_d;
        end
    end

    assign register_addr = register_addr_q;
    assign register_data = register_data_q;
    assign register_rdy  = register_rdy_q;
    assign rqst_data     = rqst_data_q;
    assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_reg_bus_cmd_decoder.sv
// Directed bench for reg_bus_cmd_decoder: stimulus pushes expected strobe events, a negedge monitor pops them.
module tb_reg_bus_cmd_decoder;

    localparam int TMO = 20;
    localparam logic [2:0] K_WR = 3'b001;
    localparam logic [2:0] K_RQ = 3'b010;
    localparam logic [2:0] K_ER = 3'b100;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic [7:0]  register_addr;
    logic [15:0] register_data;
    logic        register_rdy;
    logic        rqst_data;
    logic        frame_err;

    typedef struct {
        logic [2:0]  kind;
        int unsigned ed;
        logic [7:0]  a;
        logic [15:0] d;
    } ev_t;

    ev_t         exp_q[$];
    int unsigned edge_n;
    int          tests;
    int          fails;

    int          m_st;
    logic [7:0]  m_addr;
    logic [7:0]  m_lo;

    reg_bus_cmd_decoder #(
        .TIMEOUT_CYCLES(TMO),
        .TIMEOUT_WIDTH (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_rdy       (rx_rdy),
        .register_addr(register_addr),
        .register_data(register_data),
        .register_rdy (register_rdy),
        .rqst_data    (rqst_data),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push_ev(input logic [2:0] k, input int unsigned ed,
                           input logic [7:0] a, input logic [15:0] d);
        ev_t e;
        e.kind = k; e.ed = ed; e.a = a; e.d = d;
        exp_q.push_back(e);
    endtask

    // Drives one byte for one cycle; the reference frame model predicts its strobe.
    task automatic send_byte(input logic [7:0] b);
        int unsigned ed;
        ed = edge_n + 1;
        rx_data = b;
        rx_rdy  = 1'b1;
        case (m_st)
            0: begin
                if (b == 8'h01)      m_st = 1;
                else if (b == 8'h02) push_ev(K_RQ, ed, 8'h00, 16'h0000);
                else                 push_ev(K_ER, ed, 8'h00, 16'h0000);
            end
            1: begin m_addr = b; m_st = 2; end
            2: begin m_lo = b; m_st = 3; end
            default: begin push_ev(K_WR, ed, m_addr, {b, m_lo}); m_st = 0; end
        endcase
        @(posedge clk); #1;
        rx_rdy  = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (exp_q.size() != 0 && exp_q[0].ed < edge_n) begin
            chk("missed_event_edge", edge_n, exp_q[0].ed);
            void'(exp_q.pop_front());
        end
        if (register_rdy || rqst_data || frame_err) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {29'd0, frame_err, rqst_data, register_rdy}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_kind", {29'd0, frame_err, rqst_data, register_rdy}, {29'd0, e.kind});
                chk("strobe_edge", edge_n, e.ed);
                if (e.kind == K_WR) begin
                    chk("wr_addr", {24'd0, register_addr}, {24'd0, e.a});
                    chk("wr_data", {16'd0, register_data}, {16'd0, e.d});
                end
            end
        end
    end

    initial begin
        logic [31:0] t_e0;
        tests  = 0;
        fails  = 0;
        m_st   = 0;
        m_addr = 8'h00;
        m_lo   = 8'h00;
        rst     = 1'b0;
        rx_rdy  = 1'b0;
        rx_data = 8'h00;
        idle(3);
        chk("rst_addr", {24'd0, register_addr}, 32'd0);
        chk("rst_data", {16'd0, register_data}, 32'd0);
        chk("rst_rdy",  {31'd0, register_rdy}, 32'd0);
        chk("rst_rqst", {31'd0, rqst_data}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        rst = 1'b1;
        idle(2);

        // Write then a request opcode arriving while register_rdy is high.
        send_byte(8'h01); send_byte(8'h04); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'h02);
        idle(3);
        chk("held_addr_1", {24'd0, register_addr}, 32'h04);
        chk("held_data_1", {16'd0, register_data}, 32'h1234);
        chk("held_rdy_1",  {31'd0, register_rdy}, 32'd0);

        send_byte(8'h7F);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'hE1); send_byte(8'h00);
        idle(3);
        chk("held_addr_2", {24'd0, register_addr}, 32'h00);
        chk("held_data_2", {16'd0, register_data}, 32'h00E1);

        // Timeout mid-frame: pulse one edge after the count reaches TMO.
        send_byte(8'h01); send_byte(8'h03);
        t_e0 = edge_n;
        push_ev(K_ER, t_e0 + TMO + 1, 8'h00, 16'h0000);
        m_st = 0;
        idle(TMO + 4);
        send_byte(8'h01); send_byte(8'h03); send_byte(8'h01); send_byte(8'h00);
        idle(3);
        chk("tmo_addr", {24'd0, register_addr}, 32'h03);
        chk("tmo_data", {16'd0, register_data}, 32'h0001);

        // Byte on the exact expiry cycle is accepted.
        send_byte(8'h01); send_byte(8'h07);
        idle(TMO);
        send_byte(8'h55);
        idle(TMO);
        send_byte(8'h66);
        idle(3);
        chk("edge_addr", {24'd0, register_addr}, 32'h07);
        chk("edge_data", {16'd0, register_data}, 32'h6655);

        // Reset mid-frame discards the frame.
        send_byte(8'h01); send_byte(8'h05); send_byte(8'hAA);
        rst = 1'b0;
        m_st = 0;
        idle(2);
        chk("mrst_addr", {24'd0, register_addr}, 32'd0);
        chk("mrst_data", {16'd0, register_data}, 32'd0);
        chk("mrst_rdy",  {31'd0, register_rdy}, 32'd0);
        rst = 1'b1;
        idle(1);
        send_byte(8'hBB);
        idle(3);
        chk("post_rst_addr", {24'd0, register_addr}, 32'd0);
        chk("post_rst_data", {16'd0, register_data}, 32'd0);

        idle(3);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
